regfile_2r1w: RTL and testbench
===============================

Name: regfile_2r1w

Overview:
- 32-entry x 64-bit architectural register file built from the team's per-bit enabled-register cells, one cell per bit.
- One synchronous write port and two asynchronous read ports.
- Sits between the writeback stage, which drives the write port, and the operand-fetch/ALU stage, which consumes the read ports.
- The last entry is hardwired to zero.
- Optional write-to-read bypass lets a value written in cycle N be seen by a read of the same address in cycle N.

Parameters:
- WIDTH, 64, data width of each entry.
- DEPTH, 32, number of entries; must be a power of two.
- AW, 5, address width; must equal log2(DEPTH).
- BYPASS, 1, 1 = same-cycle write-to-read forwarding; 0 = reads return stored value only.

Ports:
- clk  input  1  single clock, rising-edge active.
- rst  input  1  synchronous, active-high reset.
- wr_en  input  1  write enable, sampled at rising clk.
- wr_addr  input  AW  write address.
- wr_data  input  WIDTH  write data.
- rd_addr1  input  AW  read port 1 address.
- rd_addr2  input  AW  read port 2 address.
- rd_data1  output  WIDTH  read port 1 data, combinational.
- rd_data2  output  WIDTH  read port 2 data, combinational.

Behaviour:
- Reset:
  - rst is synchronous and active-high.
  - On a rising clk with rst=1, every entry clears to 0, regardless of wr_en.
  - rst has priority over a simultaneous write.
  - With all entries cleared, rd_data1 and rd_data2 read 0 for any address from the first clock after reset.
- Write decode:
  - wr_addr is decoded one-hot to DEPTH enables, gated by wr_en.
  - Entry k's enable = wr_en & (wr_addr==k) & (k != DEPTH-1).
  - Each entry is a bank of WIDTH enabled-register bits: it holds when its enable is 0 and loads wr_data at the rising clk when its enable is 1.
- Write latency: the stored value updates at the rising clk where wr_en=1; it is visible from the stored array one cycle after the write is presented.
- Zero register:
  - Entry DEPTH-1 (index 31) always reads 0.
  - Writes to it are ignored.
  - It is never bypassed.
- Read:
  - Purely combinational from rd_addr and stored state.
  - Each port uses a DEPTH:1 mux tree; no registers on the read path.
  - Both ports are independent: same or different addresses, any combination.
- Bypass (BYPASS=1), per port p: if wr_en=1, wr_addr==rd_addrp, wr_addr!=DEPTH-1 and rst=0, then rd_datap = wr_data in the same cycle. Otherwise rd_datap = stored entry.
- Bypass (BYPASS=0): a same-cycle read of the address being written returns the old value; the new value appears the next cycle.
- Boundary conditions:
  - Simultaneous write and both reads of the same address: both ports bypass identically.
  - Back-to-back writes to the same address: the last one wins.
  - wr_en=0 with any wr_addr/wr_data, including X on the data: no entry changes.
  - rst asserted mid-stream: the next rising edge clears all entries; the bypass is suppressed while rst=1.
- No handshake: a write is accepted every cycle that wr_en=1 and there is no stall output.

Test Plan:
1. Reset clears all entries:
   - Stimulus: rst=1 for one clk, then rst=0; read every address on both ports.
   - Required response: every read returns 64'h0.
2. Full write-then-read sweep:
   - Stimulus: for k=0..31, write entry k with data 64'h0100_0000_0000_0000 + k; afterwards read addr k on port 1 and addr 31-k on port 2.
   - Required response: port 1 returns the written value for k=0..30, and entry 31 reads 0.
3. Zero register:
   - Stimulus: write 64'hFFFF_FFFF_FFFF_FFFF to addr 31 with rd_addr1=31 in the same cycle.
   - Required response: rd_data1=0 in that cycle and on every subsequent cycle.
4. Bypass with BYPASS=1:
   - Stimulus: entry 5 holds 64'hA; present wr_en=1, wr_addr=5, wr_data=64'hB, with rd_addr1=rd_addr2=5.
   - Required response: both ports show 64'hB before the edge and 64'hB after it.
   - Repeat with BYPASS=0: both ports show 64'hA before the edge and 64'hB after it.
5. Enable and reset gating:
   - Stimulus A: wr_en=0, wr_addr=7, wr_data=64'h1234; clk.
   - Required response: entry 7 is unchanged.
   - Stimulus B: rst=1 together with wr_en=1, wr_addr=3, wr_data=64'h55; clk.
   - Required response: entry 3 reads 0.
6. Randomised check:
   - Stimulus: 2000 cycles of random wr_en, addresses and data.
   - Required response: both read ports match a reference model every cycle, including bypass and the entry-31 rule.

Source files
------------

// File: rtl/regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : regfile_2r1w_bit
// Brief    : One enabled-register bit cell with synchronous active-high clear.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w_bit (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_d,
    output logic o_q
);

    logic r_bit_q;
    logic w_bit_d;

    // Next value: load the data bit when enabled, otherwise hold.
    always_comb begin
        w_bit_d = r_bit_q;
        if (i_en) begin
            w_bit_d = i_d;
        end
    end

    // State bit; clear has priority over a load in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bit_q <= 1'b0;
        end else begin
            r_bit_q <= w_bit_d;
        end
    end

    assign o_q = r_bit_q;

endmodule

// ============================================================================
// Module   : regfile_2r1w
// Brief    : DEPTH x WIDTH register file, one synchronous write port, two
//            combinational read ports, last entry hardwired to zero, optional
//            same-cycle write-to-read forwarding.
// Revision : 1.0 - initial release
// ============================================================================
module regfile_2r1w #(
    parameter int WIDTH  = 64,
    parameter int DEPTH  = 32,
    parameter int AW     = 5,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr1,
    input  logic [AW-1:0]    rd_addr2,
    output logic [WIDTH-1:0] rd_data1,
    output logic [WIDTH-1:0] rd_data2
);

    localparam logic [AW-1:0] c_ZERO_ADDR = AW'(DEPTH - 1);

    logic [DEPTH-1:0] w_wen;
    logic [WIDTH-1:0] w_entry [DEPTH];
    logic             w_fwd_ok;

    // One-hot write decode; the zero entry never gets an enable.
    always_comb begin
        w_wen = '0;
        for (int k = 0; k < DEPTH - 1; k++) begin
            w_wen[k] = wr_en && (wr_addr == AW'(k));
        end
    end

    // Storage: one enabled-register cell per bit of every writable entry.
    generate
        for (genvar k = 0; k < DEPTH - 1; k++) begin : g_entry
            for (genvar b = 0; b < WIDTH; b++) begin : g_bit
                regfile_2r1w_bit u_cell (
                    .clk  (clk),
                    .rst  (rst),
                    .i_en (w_wen[k]),
                    .i_d  (wr_data[b]),
                    .o_q  (w_entry[k][b])
                );
            end
        end
    endgenerate

    // The last entry has no storage and always reads zero.
    assign w_entry[DEPTH-1] = '0;

    // A write may be forwarded only when it will actually land in storage.
    generate
        if (BYPASS != 0) begin : g_bypass
            assign w_fwd_ok = wr_en && !rst && (wr_addr != c_ZERO_ADDR);
        end else begin : g_no_bypass
            assign w_fwd_ok = 1'b0;
        end
    endgenerate

    // Read port 1: forwarded write data on an address hit, else stored entry.
    always_comb begin
        rd_data1 = w_entry[rd_addr1];
        if (w_fwd_ok && (wr_addr == rd_addr1)) begin
            rd_data1 = wr_data;
        end
    end

    // Read port 2: same selection, independent address.
    always_comb begin
        rd_data2 = w_entry[rd_addr2];
        if (w_fwd_ok && (wr_addr == rd_addr2)) begin
            rd_data2 = wr_data;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_2r1w.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_2r1w
// Brief    : Self-checking bench for regfile_2r1w, forwarding and
//            non-forwarding builds driven side by side from one stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_regfile_2r1w;

    localparam int c_W = 64;
    localparam int c_D = 32;
    localparam int c_A = 5;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           wr_en = 1'b0;
    logic [c_A-1:0] wr_addr = '0;
    logic [c_W-1:0] wr_data = '0;
    logic [c_A-1:0] rd_addr1 = '0;
    logic [c_A-1:0] rd_addr2 = '0;
    logic [c_W-1:0] rd_data1, rd_data2, nb_data1, nb_data2;

    regfile_2r1w #(.WIDTH(c_W), .DEPTH(c_D), .AW(c_A), .BYPASS(1)) u_dut (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(rd_data1), .rd_data2(rd_data2)
    );

    regfile_2r1w #(.WIDTH(c_W), .DEPTH(c_D), .AW(c_A), .BYPASS(0)) u_dut_nb (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_data1(nb_data1), .rd_data2(nb_data2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [c_W-1:0] b1;
        logic [c_W-1:0] b2;
        logic [c_W-1:0] n1;
        logic [c_W-1:0] n2;
    } exp_t;

    exp_t           sb[$];
    exp_t           e;
    logic [c_W-1:0] model [c_D];
    int             errors = 0;
    int             checks = 0;

    // Reference value for a forwarding read port.
    function automatic logic [c_W-1:0] ref_byp(input logic [c_A-1:0] ra);
        if (!rst && wr_en && (wr_addr == ra) && (wr_addr != 5'd31)) return wr_data;
        return model[ra];
    endfunction

    // Compute expected outputs for the inputs currently applied and queue them.
    task automatic push_exp();
        exp_t x;
        x.b1 = ref_byp(rd_addr1);
        x.b2 = ref_byp(rd_addr2);
        x.n1 = model[rd_addr1];
        x.n2 = model[rd_addr2];
        sb.push_back(x);
    endtask

    // Advance one clock, applying the same edge semantics to the model.
    task automatic tick();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < c_D; i++) model[i] = '0;
        end else if (wr_en && wr_addr != 5'd31) begin
            model[wr_addr] = wr_data;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; wr_en = 1'b0;
        tick();
        rst = 1'b0;
        for (int a = 0; a < c_D; a++) begin
            rd_addr1 = c_A'(a); rd_addr2 = c_A'(c_D - 1 - a);
            #1 push_exp();
            #1 e = sb.pop_front(); checks++;
            if ({rd_data1, rd_data2, nb_data1, nb_data2} !== {e.b1, e.b2, e.n1, e.n2} || e.b1 !== '0) begin
                errors++;
                $display("FAIL reset a=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", a,
                         rd_data1, rd_data2, nb_data1, nb_data2, e.b1, e.b2, e.n1, e.n2);
            end
            tick();
        end
    endtask

    task automatic test_sweep();
        for (int k = 0; k < c_D; k++) begin
            wr_en = 1'b1; wr_addr = c_A'(k); wr_data = 64'h0100_0000_0000_0000 + 64'(k);
            rd_addr1 = c_A'(k); rd_addr2 = c_A'(c_D - 1 - k);
            #1 push_exp();
            #1 e = sb.pop_front(); checks++;
            if ({rd_data1, rd_data2, nb_data1, nb_data2} !== {e.b1, e.b2, e.n1, e.n2}) begin
                errors++;
                $display("FAIL sweep_wr k=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", k,
                         rd_data1, rd_data2, nb_data1, nb_data2, e.b1, e.b2, e.n1, e.n2);
            end
            tick();
        end
        wr_en = 1'b0;
        for (int k = 0; k < c_D; k++) begin
            rd_addr1 = c_A'(k); rd_addr2 = c_A'(c_D - 1 - k);
            #1 push_exp();
            #1 e = sb.pop_front(); checks++;
            if ({rd_data1, rd_data2, nb_data1, nb_data2} !== {e.b1, e.b2, e.n1, e.n2} ||
                rd_data1 !== ((k == c_D - 1) ? 64'h0 : 64'h0100_0000_0000_0000 + 64'(k))) begin
                errors++;
                $display("FAIL sweep_rd k=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", k,
                         rd_data1, rd_data2, nb_data1, nb_data2, e.b1, e.b2, e.n1, e.n2);
            end
            tick();
        end
    endtask

    task automatic test_zero_reg();
        wr_en = 1'b1; wr_addr = 5'd31; wr_data = '1;
        rd_addr1 = 5'd31; rd_addr2 = 5'd31;
        for (int c = 0; c < 4; c++) begin
            if (c > 0) wr_en = 1'b0;
            #1 push_exp();
            #1 e = sb.pop_front(); checks++;
            if ({rd_data1, rd_data2, nb_data1, nb_data2} !== {e.b1, e.b2, e.n1, e.n2} || rd_data1 !== '0) begin
                errors++;
                $display("FAIL zero_reg c=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", c,
                         rd_data1, rd_data2, nb_data1, nb_data2, e.b1, e.b2, e.n1, e.n2);
            end
            tick();
        end
    endtask

    task automatic test_bypass();
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 64'hA;
        tick();
        wr_data = 64'hB; rd_addr1 = 5'd5; rd_addr2 = 5'd5;
        for (int c = 0; c < 2; c++) begin
            #1 push_exp();
            #1 e = sb.pop_front(); checks++;
            if ({rd_data1, rd_data2, nb_data1, nb_data2} !== {e.b1, e.b2, e.n1, e.n2} ||
                rd_data1 !== 64'hB || nb_data1 !== ((c == 0) ? 64'hA : 64'hB)) begin
                errors++;
                $display("FAIL bypass c=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", c,
                         rd_data1, rd_data2, nb_data1, nb_data2, e.b1, e.b2, e.n1, e.n2);
            end
            tick();
            wr_en = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        rd_addr1 = 5'd9; rd_addr2 = 5'd9; wr_addr = 5'd9; wr_en = 1'b1;
        for (int c = 0; c < 3; c++) begin
            wr_data = 64'hC0DE_0000_0000_0000 + 64'(c);
            if (c == 2) wr_en = 1'b0;
            #1 push_exp();
            #1 e = sb.pop_front(); checks++;
            if ({rd_data1, rd_data2, nb_data1, nb_data2} !== {e.b1, e.b2, e.n1, e.n2}) begin
                errors++;
                $display("FAIL back_to_back c=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", c,
                         rd_data1, rd_data2, nb_data1, nb_data2, e.b1, e.b2, e.n1, e.n2);
            end
            tick();
        end
    endtask

    task automatic test_gating();
        rd_addr1 = 5'd7; rd_addr2 = 5'd3;
        for (int c = 0; c < 5; c++) begin
            case (c)
                0: begin wr_en = 1'b0; wr_addr = 5'd7; wr_data = 64'h1234; end
                1: begin wr_en = 1'b0; wr_addr = 5'd7; wr_data = 'x; end
                2: begin rst = 1'b1; wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'h55; rd_addr1 = 5'd3; end
                default: begin rst = 1'b0; wr_en = 1'b0; wr_data = '0; end
            endcase
            #1 push_exp();
            #1 e = sb.pop_front(); checks++;
            if ({rd_data1, rd_data2, nb_data1, nb_data2} !== {e.b1, e.b2, e.n1, e.n2}) begin
                errors++;
                $display("FAIL gating c=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", c,
                         rd_data1, rd_data2, nb_data1, nb_data2, e.b1, e.b2, e.n1, e.n2);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 2000; c++) begin
            rst      = ($urandom_range(63) == 0);
            wr_en    = $urandom_range(1);
            wr_addr  = c_A'($urandom);
            wr_data  = {$urandom, $urandom};
            rd_addr1 = ($urandom_range(3) == 0) ? wr_addr : c_A'($urandom);
            rd_addr2 = ($urandom_range(3) == 0) ? wr_addr : c_A'($urandom);
            #1 push_exp();
            #1 e = sb.pop_front(); checks++;
            if ({rd_data1, rd_data2, nb_data1, nb_data2} !== {e.b1, e.b2, e.n1, e.n2}) begin
                errors++;
                $display("FAIL random c=%0d got=%h/%h/%h/%h exp=%h/%h/%h/%h", c,
                         rd_data1, rd_data2, nb_data1, nb_data2, e.b1, e.b2, e.n1, e.n2);
            end
            tick();
        end
        rst = 1'b0; wr_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < c_D; i++) model[i] = '0;
        test_reset();
        test_sweep();
        test_zero_reg();
        test_bypass();
        test_back_to_back();
        test_gating();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
